// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

  // Two's complement negation at the widest supported width; callers truncate.
  function automatic logic [MAX_W-1:0] neg2(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  // Magnitude of a sign-extended value; the most-negative operand maps to 2^(W-1).
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x);
    return x[MAX_W-1] ? neg2(x) : x;
  endfunction

endpackage

// File: rtl/multiplier_seq_param_if.sv
// Operand/result bus of the sequential multiplier.
interface multiplier_seq_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 start;
  logic                 mode_signed;
  logic [WIDTH-1:0]     data_in;
  logic [2*WIDTH-1:0]   result;
  logic                 done;
  logic                 busy;

  modport master (
    output start, mode_signed, data_in,
    input  result, done, busy
  );

  modport slave (
    input  start, mode_signed, data_in,
    output result, done, busy
  );
endinterface

// File: rtl/mult_shift_add_core.sv
// Radix-2 shift-add datapath: accumulator, operand shift registers and step counter.
module mult_shift_add_core
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 finish,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic [2*WIDTH-1:0]   sum_c,
  output logic                 last_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_w(WIDTH);

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  // Accumulator value after the current step, so the final sum is visible on the last edge.
  assign sum_c  = acc + (mplier[0] ? mcand : '0);
  assign last_c = (count == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset || finish) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= PW'(mcand_in);
      mplier <= mplier_in;
      count  <= '0;
    end else if (step) begin
      acc    <= sum_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/multiplier_seq_param.sv
// Sequential WIDTH x WIDTH multiplier with serial operand load and optional signed mode.
module multiplier_seq_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  multiplier_seq_param_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic             sgn_reg;
  logic             neg_reg;
  logic [PW-1:0]    result_reg;
  logic             done_reg;

  logic             load;
  logic             step;
  logic             finish;
  logic             last_c;
  logic [WIDTH-1:0] mcand_in;
  logic [WIDTH-1:0] mplier_in;
  logic [PW-1:0]    sum_c;
  logic [PW-1:0]    prod_c;

  assign load   = (state == LOAD_B);
  assign step   = (state == CALC);
  assign finish = (state == DONE);

  // Signed operands enter the core as magnitudes; the sign is reapplied at the end.
  always_comb begin
    mcand_in  = a_reg;
    mplier_in = bus.data_in;
    if (sgn_reg) begin
      mcand_in  = WIDTH'(abs_val(MAX_W'(signed'(a_reg))));
      mplier_in = WIDTH'(abs_val(MAX_W'(signed'(bus.data_in))));
    end
  end

  assign prod_c = neg_reg ? PW'(neg2(MAX_W'(sum_c))) : sum_c;

  mult_shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .mcand_in  (mcand_in),
    .mplier_in (mplier_in),
    .sum_c     (sum_c),
    .last_c    (last_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      sgn_reg    <= 1'b0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.data_in;
            sgn_reg <= SIGNED_EN & bus.mode_signed;
            state   <= LOAD_B;
          end
        end
        LOAD_B: begin
          neg_reg <= sgn_reg & (a_reg[WIDTH-1] ^ bus.data_in[WIDTH-1]);
          state   <= CALC;
        end
        CALC: begin
          if (last_c) begin
            result_reg <= prod_c;
            done_reg   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          a_reg   <= '0;
          sgn_reg <= 1'b0;
          neg_reg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.done   = done_reg;
  assign bus.busy   = (state != IDLE);

endmodule

// File: doc/multiplier_seq_param.md
Name: multiplier_seq_param

Overview:
Parametrised sequential multiplier, successor to the 4-bit repeated-addition multiplier. Operands arrive serially on a shared data_in bus: A in the start cycle, B in the next cycle. Computes a WIDTH x WIDTH product in a fixed WIDTH-cycle radix-2 shift-add loop. Adds optional signed (two's complement) mode and a busy indication; latency is independent of operand values.

Parameters:
WIDTH, 4, operand width in bits; legal values 2..32; result is 2*WIDTH bits.
SIGNED_EN, 1, 1 = mode_signed honoured; 0 = mode_signed ignored, always unsigned.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
start  input  1  request; sampled only in IDLE; data_in carries A in that same cycle.
mode_signed  input  1  sampled with start; 1 = operands and result are two's complement.
data_in  input  WIDTH  operand bus: A in the start cycle, B in the following cycle.
result  output  2*WIDTH  product; registered; held until the next completion or reset.
done  output  1  one-cycle pulse; result valid and updated in the same cycle.
busy  output  1  high from the cycle after start is accepted until done, inclusive.

Behaviour:
- Reset: reset==0 at a clock edge forces state IDLE, result=0, done=0, busy=0, and clears all internal registers. Reset overrides every other input.
- Reset mid-operation: the operation is abandoned silently, with no done pulse and result=0.
- States: IDLE -> LOAD_B -> CALC -> DONE -> IDLE.
- IDLE: when start=1, capture A and mode (mode forced to 0 if SIGNED_EN=0), then go to LOAD_B. When start=0, stay in IDLE.
- LOAD_B: capture data_in as B, clear the accumulator, set count=0, go to CALC. start is ignored here.
- CALC, unsigned mode:
  - Each cycle, if the multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH accumulator.
  - Shift the multiplier right and the multiplicand left.
  - count increments; after exactly WIDTH cycles (count==WIDTH-1) go to DONE.
- CALC, signed mode:
  - A and B are converted to magnitude in LOAD_B/CALC entry.
  - The most-negative value maps to 2^(WIDTH-1); this fits in WIDTH unsigned bits.
  - neg = sign(A) XOR sign(B); the accumulated magnitude is negated modulo 2^(2*WIDTH) on entry to DONE if neg=1.
- DONE: result register loaded on the edge entering DONE; done=1 and busy=1 for exactly this one cycle; then IDLE.
- Latency: start high in cycle N gives done high in cycle N+WIDTH+2. For WIDTH=4 this is cycle N+6.
- Throughput: next start is accepted in cycle N+WIDTH+3 at the earliest.
- start while busy, including the DONE cycle: ignored, with no queueing and no effect on the operation in flight.
- Width rule: all arithmetic is 2*WIDTH bits wide; no overflow is possible in either mode.
  - Example: (-2^(W-1))^2 = 2^(2W-2), which fits as a positive signed value.
- Zero operand: no early exit; latency is identical to any other operand pair.
- busy: combinational decode of state != IDLE from registered state; glitch-free relative to clock.
- data_in in cycles other than start and start+1 is don't-care.

Decomposition:
- Package mult_pkg:
  - state enum (IDLE, LOAD_B, CALC, DONE), 2-bit encoding.
  - function cnt_w(WIDTH) = $clog2(WIDTH).
  - helper functions abs_val and neg2 for sign handling.
- Sub-module mult_shift_add_core:
  - Holds accumulator, multiplicand/multiplier shift registers and the iteration counter.
  - Controls: load, step, finish.
  - The top level holds the FSM, operand sequencing, sign handling and the result/done registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 toggling -> result=0, done=0, busy=0 throughout; after release, an op with A=3, B=5, unsigned -> result=15 (0x0F).
- Unsigned max, WIDTH=4: start in cycle 0 with A=0xF, then B=0xF, mode_signed=0 -> done only in cycle 6, result=0xE1 (225), busy high cycles 1-6.
- Signed vs unsigned: A=0x8, B=0x7:
  - mode_signed=1 -> result=0xC8 (-56).
  - mode_signed=0 -> result=0x38 (56).
  - A=0x8, B=0x8 signed -> result=0x40 (64).
- Zero operand: A=0, B=9 -> result=0x00; done still in cycle 6; previous result held until then.
- Busy-start rejection: start pulses in cycles 2, 4 and 6 (the DONE cycle) with different data -> first result unaffected, exactly one done; a start in cycle 7 is accepted, giving done in cycle 13.
- Mid-op reset: reset=0 in cycle 4 of an op -> no done pulse, result=0, state IDLE next cycle; a following op with A=2, B=6 -> result=12.
- WIDTH=8 regression: A=0x80, B=0xFF signed -> result=0x0080 (+128), done in cycle 10; the same operands unsigned -> result=0x7F80.
